io_irq_ctrl: RTL and testbench

Parametrised, memory-mapped interrupt controller for the I/O subsystem. It replaces the fixed three-source OR-and-priority logic with NUM_SRC sources, each with its own pending latch, mask bit and edge/level mode. It produces a registered IRQ and interrupt number (IDN) for the system register file. The CPU acknowledges the winning source or clears bits through the data bus window.

---
 rtl/irq_ctrl_pkg.sv | 24 ++
 rtl/irq_src_sync.sv | 35 +++
 rtl/io_irq_ctrl.sv | 105 ++++++++++
 tb/tb_io_irq_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared constants and priority encoder for io_irq_ctrl (IRQ_CTRL_SYNC_EN selects source synchronisers).
// Offsets are byte offsets within the 16-byte register window.
package irq_ctrl_pkg;

  localparam logic [3:0] OFS_PEND = 4'h0;
  localparam logic [3:0] OFS_MASK = 4'h4;
  localparam logic [3:0] OFS_MODE = 4'h8;
  localparam logic [3:0] OFS_STAT = 4'hC;

  localparam int IDN_W   = 4;
  localparam int MAX_SRC = 14;
  localparam logic [IDN_W-1:0] IDN_NONE = 4'hF;

  // Lowest set index wins; result is index + 1 so that 0 never appears as a valid number.
  function automatic logic [IDN_W-1:0] prio_enc(input logic [MAX_SRC-1:0] act);
    logic [IDN_W-1:0] res;
    res = IDN_NONE;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (act[i]) res = IDN_W'(i + 1);
    end
    return res;
  endfunction

endpackage

// File: rtl/irq_src_sync.sv
// One interrupt source: optional 2-flop synchroniser (IRQ_CTRL_SYNC_EN), previous-value flop, set logic.
// Latency: set is combinational from s_cur; the synchroniser adds two cycles ahead of s_cur.
module irq_src_sync (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic mode,
  output logic set
);

  logic w_cur;
  logic r_prev;

`ifdef IRQ_CTRL_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= 2'b00;
    else     r_sync <= {r_sync[0], src};
  end

  assign w_cur = r_sync[1];
`else
  assign w_cur = src;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= w_cur;
  end

  // mode = 1 selects rising-edge detection, 0 passes the level through.
  assign set = mode ? (w_cur & ~r_prev) : w_cur;

endmodule

// File: rtl/io_irq_ctrl.sv
// Memory-mapped interrupt controller: per-source pending/mask/mode, registered irq and idn.
// Source to PEND in the sampling cycle (plus two with IRQ_CTRL_SYNC_EN), irq/idn one cycle later; reads are combinational.
module io_irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          NUM_SRC   = 4,
  parameter logic [31:0] BASE_ADDR = 32'hF0000020,
  parameter int          DBITS     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DBITS-1:0]   addr,
  input  logic [DBITS-1:0]   wdata,
  input  logic               we,
  output logic [DBITS-1:0]   rdata,
  output logic               rd_hit,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               ie,
  input  logic               ack,
  output logic               irq,
  output logic [IDN_W-1:0]   idn
);

  logic [NUM_SRC-1:0] r_pend, r_mask, r_mode;
  logic [NUM_SRC-1:0] w_set, w_w1c, w_ack_clr, w_clr, w_active;
  logic [MAX_SRC-1:0] w_act_ext;
  logic [3:0]         w_ofs;
  logic               w_hit, w_wr;
  logic               r_irq;
  logic [IDN_W-1:0]   r_idn;
  logic [DBITS-1:0]   w_stat;
  logic               w_unused;

  assign w_hit  = (addr[DBITS-1:4] == BASE_ADDR[DBITS-1:4]);
  assign w_ofs  = {addr[3:2], 2'b00};
  assign w_wr   = we & w_hit;
  assign rd_hit = w_hit;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_src_sync u_src (
      .clk  (clk),
      .rst  (rst),
      .src  (src_irq[g]),
      .mode (r_mode[g]),
      .set  (w_set[g])
    );
  end

  // ack retires whichever source is currently advertised on idn.
  always_comb begin
    w_ack_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ack && (r_idn == IDN_W'(i + 1))) w_ack_clr[i] = 1'b1;
    end
  end

  assign w_w1c    = (w_wr && (w_ofs == OFS_PEND)) ? wdata[NUM_SRC-1:0] : '0;
  assign w_clr    = w_w1c | w_ack_clr;
  assign w_active = r_pend & r_mask;

  always_comb begin
    w_act_ext = '0;
    w_act_ext[NUM_SRC-1:0] = w_active;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_mask <= '0;
      r_mode <= '1;
      r_irq  <= 1'b0;
      r_idn  <= IDN_NONE;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_set;
      if (w_wr && (w_ofs == OFS_MASK)) r_mask <= wdata[NUM_SRC-1:0];
      if (w_wr && (w_ofs == OFS_MODE)) r_mode <= wdata[NUM_SRC-1:0];
      r_irq  <= ie & (|w_active);
      r_idn  <= prio_enc(w_act_ext);
    end
  end

  always_comb begin
    w_stat = '0;
    w_stat[DBITS-1]   = r_irq;
    w_stat[IDN_W-1:0] = r_idn;
  end

  always_comb begin
    rdata = '0;
    if (w_hit) begin
      case (w_ofs)
        OFS_PEND: rdata = DBITS'(r_pend);
        OFS_MASK: rdata = DBITS'(r_mask);
        OFS_MODE: rdata = DBITS'(r_mode);
        default:  rdata = w_stat;
      endcase
    end
  end

  assign irq = r_irq;
  assign idn = r_idn;

  assign w_unused = ^{addr[1:0], wdata[DBITS-1:NUM_SRC]};

endmodule

// File: tb/tb_io_irq_ctrl.sv
// Directed bench for io_irq_ctrl; expectations queue per cycle, a negedge monitor pops and compares.
module tb_io_irq_ctrl;

  localparam logic [31:0] BASE = 32'hF0000020;
  localparam logic [31:0] IDLE = 32'h0000_0000;
`ifdef IRQ_CTRL_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  localparam int K_RDATA = 0;
  localparam int K_HIT   = 1;
  localparam int K_IRQ   = 2;
  localparam int K_IDN   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = IDLE;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic [31:0] rdata;
  logic        rd_hit;
  logic [3:0]  src_irq = '0;
  logic        ie = 1'b0;
  logic        ack = 1'b0;
  logic        irq;
  logic [3:0]  idn;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] v;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t item;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] act;

  io_irq_ctrl #(.NUM_SRC(4), .BASE_ADDR(BASE), .DBITS(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .wdata   (wdata),
    .we      (we),
    .rdata   (rdata),
    .rd_hit  (rd_hit),
    .src_irq (src_irq),
    .ie      (ie),
    .ack     (ack),
    .irq     (irq),
    .idn     (idn)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      item = sb.pop_front();
      case (item.kind)
        K_RDATA: act = rdata;
        K_HIT:   act = {31'b0, rd_hit};
        K_IRQ:   act = {31'b0, irq};
        default: act = {28'b0, idn};
      endcase
      checks++;
      if (act !== item.v) begin
        errors++;
        $display("FAIL %s: got %h, expected %h (cycle %0d)", item.nm, act, item.v, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input int kind, input logic [31:0] v, input string nm);
    sb.push_back('{cyc, kind, v, nm});
  endtask

  // Drives a read address for the current cycle; caller ticks before changing addr.
  task automatic rd(input logic [3:0] ofs, input logic [31:0] v, input string nm);
    addr = BASE + {28'b0, ofs};
    expect_now(K_RDATA, v, nm);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
    addr  = IDLE;
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    expect_now(K_IRQ, 0, "rst_irq");
    expect_now(K_IDN, 32'hF, "rst_idn");
    rd(4'h0, 32'h0, "rst_pend");
    expect_now(K_HIT, 1, "rst_hit");
    tick();
    rd(4'h4, 32'h0, "rst_mask");        tick();
    rd(4'h8, 32'hF, "rst_mode");        tick();
    rd(4'hC, 32'h0000_000F, "rst_stat"); tick();
    addr = IDLE;
    expect_now(K_HIT, 0, "idle_hit");
    expect_now(K_RDATA, 0, "idle_rdata");
    tick();

    // Single source through mask, exact latency
    wr(BASE + 4, 32'h6);
    ie = 1'b1;
    src_irq = 4'b0100;
    tick();
    src_irq = 4'b0000;
    repeat (SL) tick();
    rd(4'h0, 32'h4, "s2_pend");
    expect_now(K_IRQ, 0, "s2_irq_early");
    expect_now(K_IDN, 32'hF, "s2_idn_early");
    tick();
    expect_now(K_IRQ, 1, "s2_irq");
    expect_now(K_IDN, 32'h3, "s2_idn");
    rd(4'hC, 32'h8000_0003, "s2_stat");
    tick();
    wr(BASE, 32'h4);
    expect_now(K_IRQ, 1, "w1c_irq_lag");
    rd(4'h0, 32'h0, "w1c_pend");
    tick();
    expect_now(K_IRQ, 0, "w1c_irq");
    expect_now(K_IDN, 32'hF, "w1c_idn");
    tick();

    // Two sources, priority and ack
    src_irq = 4'b0110;
    tick();
    src_irq = 4'b0000;
    repeat (SL) tick();
    tick();
    expect_now(K_IDN, 32'h2, "pri_idn");
    expect_now(K_IRQ, 1, "pri_irq");
    rd(4'h0, 32'h6, "pri_pend");
    ack = 1'b1;
    tick();
    ack = 1'b0;
    rd(4'h0, 32'h4, "ack1_pend");
    expect_now(K_IDN, 32'h2, "ack1_idn_lag");
    tick();
    expect_now(K_IDN, 32'h3, "ack1_idn");
    expect_now(K_IRQ, 1, "ack1_irq");
    ack = 1'b1;
    tick();
    ack = 1'b0;
    rd(4'h0, 32'h0, "ack2_pend");
    tick();
    expect_now(K_IDN, 32'hF, "ack2_idn");
    expect_now(K_IRQ, 0, "ack2_irq");
    tick();

    // Level mode on source 0: re-pends while held, clears once released
    wr(BASE + 8, 32'hE);
    src_irq = 4'b0001;
    repeat (SL + 1) tick();
    rd(4'h0, 32'h1, "lvl_pend");
    tick();
    wr(BASE, 32'h1);
    rd(4'h0, 32'h1, "lvl_repend");
    tick();
    src_irq = 4'b0000;
    repeat (SL) tick();
    wr(BASE, 32'h1);
    rd(4'h0, 32'h0, "lvl_clear");
    tick();
    rd(4'h0, 32'h0, "lvl_stay");
    tick();
    wr(BASE + 8, 32'hF);

    // Global enable gates irq only
    ie = 1'b0;
    src_irq = 4'b0010;
    tick();
    src_irq = 4'b0000;
    repeat (SL) tick();
    tick();
    expect_now(K_IRQ, 0, "ie0_irq");
    expect_now(K_IDN, 32'h2, "ie0_idn");
    ie = 1'b1;
    tick();
    expect_now(K_IRQ, 1, "ie1_irq");
    wr(BASE, 32'h2);
    tick();
    expect_now(K_IRQ, 0, "ie1_clr_irq");
    expect_now(K_IDN, 32'hF, "ie1_clr_idn");
    tick();

    // Set beats W1C in the same cycle
    src_irq = 4'b1000;
    repeat (SL) tick();
    wr(BASE, 32'h8);
    src_irq = 4'b0000;
    rd(4'h0, 32'h8, "setwin_pend");
    tick();
    wr(BASE, 32'h8);
    rd(4'h0, 32'h0, "setwin_clr");
    tick();

    // Out-of-window write, read-before-write, upper bits, STAT write ignored
    addr  = BASE + 32'h14;
    wdata = 32'h0;
    we    = 1'b1;
    expect_now(K_HIT, 0, "oow_hit");
    expect_now(K_RDATA, 0, "oow_rdata");
    tick();
    we = 1'b0;
    rd(4'h4, 32'h6, "oow_mask");
    tick();
    addr  = BASE + 4;
    wdata = 32'hFFFF_FFFF;
    we    = 1'b1;
    expect_now(K_RDATA, 32'h6, "rbw_mask");
    tick();
    we = 1'b0;
    rd(4'h4, 32'hF, "mask_upper");
    tick();
    wr(BASE + 32'hC, 32'h0);
    rd(4'hC, 32'h0000_000F, "stat_ro");
    tick();

    repeat (3) tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
